// File: rtl/shift_delay_compare.sv
// Delay block exposing two codings of one register chain side by side: a collapsed
// single register (blocking-style chain) and a true DEPTH-stage shift pipeline.
module shift_delay_compare #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   input  logic [WIDTH-1:0]       i_d,
   output logic [WIDTH-1:0]       o_q_blocking,
   output logic [WIDTH-1:0]       o_q_nonblock,
   output logic [DEPTH*WIDTH-1:0] o_taps,
   output logic                   o_valid,
   output logic                   o_mismatch
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] r_stage_p0;
   logic [WIDTH-1:0]            r_q_blk_p0;
   logic [CNT_W-1:0]            r_fill_cnt;
   logic                        w_valid;

   // Stage boundary: every stage and the collapsed register sample on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stage_p0 <= '0;
         r_q_blk_p0 <= '0;
      end else if (i_en) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            r_stage_p0[k] <= r_stage_p0[k-1];
         end
         r_stage_p0[0] <= i_d;
         r_q_blk_p0    <= i_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fill_cnt <= '0;
      end else if (i_en && (r_fill_cnt != CNT_FULL)) begin
         r_fill_cnt <= r_fill_cnt + 1'b1;
      end
   end

   assign w_valid      = (r_fill_cnt == CNT_FULL);
   assign o_valid      = w_valid;
   assign o_q_blocking = r_q_blk_p0;
   assign o_q_nonblock = r_stage_p0[DEPTH-1];
   assign o_taps       = r_stage_p0;
   // Built only from registered values so i_d can never glitch the flag.
   assign o_mismatch   = w_valid && (r_q_blk_p0 != r_stage_p0[DEPTH-1]);

endmodule

// File: tb/tb_shift_delay_compare.sv
// Bench for shift_delay_compare: directed vector table plus random stimulus
// against a queue-based delay model, on a DEPTH=3 and a DEPTH=1/WIDTH=8 build.
module tb_shift_delay_compare;

   logic       clk;
   logic       rst, en;
   logic       d1;
   logic [7:0] d8;

   logic       a_blk, a_nb, a_vld, a_mm;
   logic [2:0] a_taps;
   logic [7:0] b_blk, b_nb, b_taps;
   logic       b_vld, b_mm;

   int n_chk = 0;
   int n_err = 0;

   logic       q1[$];
   logic [7:0] q2[$];

   shift_delay_compare #(.WIDTH(1), .DEPTH(3)) u_a (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_d(d1),
      .o_q_blocking(a_blk), .o_q_nonblock(a_nb), .o_taps(a_taps),
      .o_valid(a_vld), .o_mismatch(a_mm)
   );

   shift_delay_compare #(.WIDTH(8), .DEPTH(1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_d(d8),
      .o_q_blocking(b_blk), .o_q_nonblock(b_nb), .o_taps(b_taps),
      .o_valid(b_vld), .o_mismatch(b_mm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, d;
      logic       blk, nb;
      logic [2:0] taps;
      logic       vld, mm;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: each path is a queue of enabled samples, newest first.
   task automatic model_edge(input logic r, input logic e, input logic dd1, input logic [7:0] dd8);
      if (r) begin
         q1.delete();
         q2.delete();
      end else if (e) begin
         q1.push_front(dd1);
         if (q1.size() > 3) void'(q1.pop_back());
         q2.push_front(dd8);
         if (q2.size() > 1) void'(q2.pop_back());
      end
   endtask

   task automatic check_model(input string tag);
      logic [2:0] m_taps;
      logic       m_blk, m_nb, m_vld;
      logic [7:0] m2;
      for (int k = 0; k < 3; k++) m_taps[k] = (k < q1.size()) ? q1[k] : 1'b0;
      m_blk = (q1.size() > 0) ? q1[0] : 1'b0;
      m_nb  = m_taps[2];
      m_vld = (q1.size() == 3);
      chk({tag, " a_blk"},  64'(a_blk),  64'(m_blk));
      chk({tag, " a_nb"},   64'(a_nb),   64'(m_nb));
      chk({tag, " a_taps"}, 64'(a_taps), 64'(m_taps));
      chk({tag, " a_vld"},  64'(a_vld),  64'(m_vld));
      chk({tag, " a_mm"},   64'(a_mm),   64'(m_vld && (m_blk != m_nb)));
      m2 = (q2.size() > 0) ? q2[0] : 8'h00;
      chk({tag, " b_blk"},  64'(b_blk),  64'(m2));
      chk({tag, " b_nb"},   64'(b_nb),   64'(m2));
      chk({tag, " b_vld"},  64'(b_vld),  64'(q2.size() == 1));
      chk({tag, " b_mm"},   64'(b_mm),   64'(0));
   endtask

   // Inputs move at a random point inside the period, then one rising edge.
   task automatic cycle(input logic r, input logic e, input logic dd1, input logic [7:0] dd8);
      #($urandom_range(0, 7));
      rst = r; en = e; d1 = dd1; d8 = dd8;
      @(posedge clk);
      model_edge(r, e, dd1, dd8);
      #1;
   endtask

   vec_t vt[$];

   initial begin
      rst = 1'b1; en = 1'b1; d1 = 1'b1; d8 = 8'hFF;
      //        rst  en  d   blk nb  taps    vld mm
      vt.push_back('{1'b1,1'b1,1'b1, 1'b0,1'b0,3'b000, 1'b0,1'b0});
      vt.push_back('{1'b1,1'b1,1'b1, 1'b0,1'b0,3'b000, 1'b0,1'b0});
      vt.push_back('{1'b0,1'b1,1'b1, 1'b1,1'b0,3'b001, 1'b0,1'b0});
      vt.push_back('{1'b0,1'b1,1'b0, 1'b0,1'b0,3'b010, 1'b0,1'b0});
      vt.push_back('{1'b0,1'b1,1'b0, 1'b0,1'b1,3'b100, 1'b1,1'b1});
      vt.push_back('{1'b0,1'b1,1'b0, 1'b0,1'b0,3'b000, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b1,1'b1, 1'b1,1'b0,3'b001, 1'b1,1'b1});
      vt.push_back('{1'b0,1'b1,1'b0, 1'b0,1'b0,3'b010, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b1,1'b1, 1'b1,1'b1,3'b101, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b0,1'b0, 1'b1,1'b1,3'b101, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b0,1'b1, 1'b1,1'b1,3'b101, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b0,1'b0, 1'b1,1'b1,3'b101, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b0,1'b1, 1'b1,1'b1,3'b101, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b0,1'b0, 1'b1,1'b1,3'b101, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b1,1'b0, 1'b0,1'b0,3'b010, 1'b1,1'b0});
      vt.push_back('{1'b0,1'b1,1'b0, 1'b0,1'b1,3'b100, 1'b1,1'b1});
      vt.push_back('{1'b1,1'b1,1'b1, 1'b0,1'b0,3'b000, 1'b0,1'b0});

      for (int i = 0; i < vt.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         cycle(vt[i].rst, vt[i].en, vt[i].d, 8'($urandom));
         chk({tag, " blk"},  64'(a_blk),  64'(vt[i].blk));
         chk({tag, " nb"},   64'(a_nb),   64'(vt[i].nb));
         chk({tag, " taps"}, 64'(a_taps), 64'(vt[i].taps));
         chk({tag, " vld"},  64'(a_vld),  64'(vt[i].vld));
         chk({tag, " mm"},   64'(a_mm),   64'(vt[i].mm));
         check_model(tag);
      end

      // Random run with a one-cycle reset injected after 10 cycles.
      for (int i = 0; i < 100; i++) begin
         logic r;
         r = (i == 10);
         cycle(r, ($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom));
         check_model($sformatf("rnd%0d", i));
         if (r) begin
            chk("midrst taps", 64'(a_taps), 64'(0));
            chk("midrst vld",  64'(a_vld),  64'(0));
         end
      end

      // Refill after reset needs exactly three enabled edges.
      cycle(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("refill%0d vld", i), 64'(a_vld), 64'(0));
         cycle(1'b0, 1'b1, 1'($urandom), 8'($urandom));
         check_model($sformatf("refill%0d", i));
      end
      chk("refill vld", 64'(a_vld), 64'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
